// File: rtl/imem_loader_if.sv
// Byte-link and instruction-memory write-port bundle for the IM loader.
// master: the loader (accepts bytes, drives the IM write port).
// slave:  the environment (byte source and instruction memory).
interface imem_loader_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int BYTE_W  = 8
);
    logic [BYTE_W-1:0]  rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (LEN, N x {HI,LO}, CHK)
// from a valid/ready byte link, writes N 16-bit words to IM addresses 0..N-1,
// holds the CPU stalled while loading and pulses pc_clear on a good checksum.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int BYTE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              pc_clear,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
    } state_t;

    // LEN byte of zero means a full memory image of 2**ADDR_W words.
    localparam logic [ADDR_W:0] REM_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W:0]     wl_q, wl_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic [BYTE_W-1:0]   chk_q, chk_d;
    logic                pc_clear_q, pc_clear_d;

    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = INSTR_W'({hi_q, lo_q});
    assign words_loaded = wl_q;
    assign pc_clear     = pc_clear_q;

    // Next-state, datapath updates and Moore output decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        wl_d         = wl_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        chk_d        = chk_q;
        pc_clear_d   = 1'b0;
        bus.rx_ready = 1'b0;
        bus.im_we    = 1'b0;
        cpu_hold     = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        case (state_q)
            S_LEN: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (bus.rx_valid) begin
                    rem_d   = (bus.rx_data == '0) ? REM_FULL : (ADDR_W+1)'(bus.rx_data);
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (bus.rx_valid) begin
                    hi_d    = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (bus.rx_valid) begin
                    lo_d    = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                busy      = 1'b1;
                bus.im_we = 1'b1;
                addr_d    = addr_q + ADDR_W'(1);
                rem_d     = rem_q - (ADDR_W+1)'(1);
                wl_d      = wl_q + (ADDR_W+1)'(1);
                state_d   = (rem_q == (ADDR_W+1)'(1)) ? S_CHK : S_HI;
            end
            S_CHK: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (bus.rx_valid) begin
                    pc_clear_d = (bus.rx_data == chk_q);
                    state_d    = (bus.rx_data == chk_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase

        // start is only honoured when no load is in progress.
        if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) && start) begin
            state_d = S_LEN;
            addr_d  = '0;
            wl_d    = '0;
            chk_d   = '0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wl_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            chk_q      <= '0;
            pc_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wl_q       <= wl_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            chk_q      <= chk_d;
            pc_clear_q <= pc_clear_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames against a frame-level
// reference model (expected IM image, checksum, word count, byte count).
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold, pc_clear, busy, done, err;
    logic [8:0] words_loaded;

    imem_loader_if bus ();

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .pc_clear     (pc_clear),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] tb_mem  [256];
    logic [15:0] exp_mem [256];
    logic [7:0]  data_q [$];
    int wr_cnt = 0, pcc_cnt = 0, acc_cnt = 0, rdy_viol = 0, last_addr = -1;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory emulation and stream/handshake observation, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            tb_mem[bus.im_addr] = bus.im_wdata;
            wr_cnt++;
            last_addr = int'(bus.im_addr);
        end
        if (pc_clear === 1'b1) pcc_cnt++;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) acc_cnt++;
        if (busy === 1'b1) begin
            if (bus.rx_ready === bus.im_we) rdy_viol++;
        end else if (bus.rx_ready !== 1'b0 || bus.im_we !== 1'b0) begin
            rdy_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
    endtask

    // gap: 0 back-to-back, 1 valid low one cycle before each byte, 2 random idle + stray start
    task automatic send_byte(input logic [7:0] b, input int gap, output int t_acc);
        int   idle;
        int   guard;
        logic acc;
        idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        if (idle > 0) begin
            bus.rx_valid = 1'b0;
            if (gap == 2) start = 1'($urandom_range(0, 1));
            repeat (idle) @(posedge clk);
            #1 start = 1'b0;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = bus.rx_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        t_acc = cyc;
    endtask

    // Sends LEN, data_q as HI/LO pairs, CHK (xored with bad) and checks the outcome.
    task automatic run_frame(input int n, input logic [7:0] bad, input int gap);
        logic [7:0] len, x;
        int         t0, t1, t, nbad;
        logic       good;
        len  = 8'(n);
        x    = len;
        good = (bad == 8'h00);
        for (int i = 0; i < n; i++) begin
            exp_mem[i] = {data_q[2*i], data_q[2*i+1]};
            x = x ^ data_q[2*i] ^ data_q[2*i+1];
        end
        wr_cnt = 0; pcc_cnt = 0; acc_cnt = 0; last_addr = -1;
        do_start();
        send_byte(len, gap, t0);
        for (int i = 0; i < 2*n; i++) send_byte(data_q[i], gap, t);
        send_byte(x ^ bad, gap, t1);
        bus.rx_valid = 1'b0;
        chk("end_done", 32'(done), 32'(good));
        chk("end_err", 32'(err), 32'(!good));
        chk("end_hold", 32'(cpu_hold), 32'(!good));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_pc_clear", 32'(pc_clear), 32'(good));
        chk("end_words", 32'(words_loaded), 32'(n));
        if (gap == 0) chk("load_cycles", 32'(t1 - t0), 32'(3*n + 1));
        repeat (3) @(posedge clk);
        #1;
        chk("pc_clear_fall", 32'(pc_clear), 32'd0);
        chk("pc_clear_pulses", 32'(pcc_cnt), 32'(good));
        chk("write_count", 32'(wr_cnt), 32'(n));
        chk("bytes_accepted", 32'(acc_cnt), 32'(2*n + 2));
        chk("last_addr", 32'(last_addr), 32'(n - 1));
        chk("words_hold", 32'(words_loaded), 32'(n));
        chk("done_hold", 32'(done), 32'(good));
        nbad = 0;
        for (int i = 0; i < n; i++) if (tb_mem[i] !== exp_mem[i]) nbad++;
        chk("im_contents", 32'(nbad), 32'd0);
    endtask

    task automatic fill_random(input int n);
        data_q = {};
        for (int i = 0; i < 2*n; i++) data_q.push_back(8'($urandom));
    endtask

    initial begin
        int t;
        int n;
        logic [7:0] bad;
        reset = 1'b0; start = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;

        // Reset state (asynchronous: checked before any clock edge)
        #2 reset = 1'b1;
        #1;
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_we", 32'(bus.im_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc_clear", 32'(pc_clear), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic two-word frame, back-to-back
        data_q = {8'h12, 8'h34, 8'hAB, 8'hCD};
        run_frame(2, 8'h00, 0);
        chk("im0_1234", 32'(tb_mem[0]), 32'h1234);
        chk("im1_abcd", 32'(tb_mem[1]), 32'hABCD);

        // Bad checksum (0x43), then retry with the good frame
        run_frame(2, 8'h01, 0);
        run_frame(2, 8'h00, 0);

        // Full memory: LEN=00 means 256 words
        fill_random(256);
        run_frame(256, 8'h00, 0);

        // Two-word frame with valid low every other cycle
        data_q = {8'h12, 8'h34, 8'hAB, 8'hCD};
        run_frame(2, 8'h00, 1);

        // Reset after the first word is written
        data_q = {8'h12, 8'h34, 8'hAB, 8'hCD};
        tb_mem[0] = 16'h0000;
        do_start();
        send_byte(8'h02, 0, t);
        send_byte(8'h12, 0, t);
        send_byte(8'h34, 0, t);
        bus.rx_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_ready", 32'(bus.rx_ready), 32'd0);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        chk("midrst_im0", 32'(tb_mem[0]), 32'h1234);
        @(negedge clk);
        reset = 1'b0;

        // Randomized frames: length, data, checksum corruption, pacing
        for (int k = 0; k < 8; k++) begin
            n   = int'($urandom_range(1, 20));
            bad = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fill_random(n);
            run_frame(n, bad, int'($urandom_range(0, 2)));
        end

        chk("ready_we_exclusive", 32'(rdy_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
